uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one `uart_tx` transmitter between `N_REQ` byte-stream requesters (e.g. CPU console, debug monitor, boot loader). It grants in round-robin order and holds a packet lock, so a requester's multi-byte message is never interleaved with another requester's. It sits between the requesters and the `uart_tx` `i_valid`/`i_data`/`o_ready` pins. It holds the transmitted byte stable for the whole frame, because `uart_tx` samples `i_data` bit by bit during transmission.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `IDLE_TIMEOUT`, default 65535: cycles a locked owner may stay idle before its lock is revoked (1..65535).
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `i_req_valid` in `N_REQ`: requester k has a byte.
- `i_req_data` in `N_REQ*8`: requester k's byte, on bits [8k+7:8k].
- `i_req_last` in `N_REQ`: the byte is the last of its packet (releases the lock).
- `o_req_ready` out `N_REQ`: one-hot; byte k is accepted in a cycle where valid[k] and ready[k] are both high.
- `o_tx_valid` out 1: connects to `uart_tx` `i_valid`.
- `o_tx_data` out 8: connects to `uart_tx` `i_data`; held stable from capture until the next capture.
- `i_tx_ready` in 1: connects to `uart_tx` `o_ready`.
- `o_owner` out `$clog2(N_REQ)`: index of the most recently granted requester.
- `o_locked` out 1: a packet lock is held by `o_owner`.
- `o_busy` out 1: the FSM is not in ARB.
- `o_timeout` out 1: one-cycle pulse when a lock is revoked.

## Operation
- FSM states: ARB, ISSUE, WAIT_BUSY, WAIT_DONE.
- **ARB, grant condition:** a grant happens only when `i_tx_ready`=1.
  - Locked: only `o_owner` is eligible.
  - Unlocked: scan from the round-robin pointer `next`, i.e. `next`, `next+1`, … wrapping mod `N_REQ`; the first requester with valid high wins.
- **ARB, on grant to requester k:**
  - `o_req_ready[k]`=1 combinationally in that cycle.
  - `o_tx_data` <= byte k; `o_owner` <= k; `next` <= (k+1) mod `N_REQ`.
  - `o_locked` <= !`i_req_last[k]`.
  - Go to ISSUE.
- **ISSUE:** `o_tx_valid`=1 for exactly this one cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** stay while `i_tx_ready`=1; on `i_tx_ready`=0 go to WAIT_DONE.
- **WAIT_DONE:** stay while `i_tx_ready`=0; on `i_tx_ready`=1 go to ARB.
- **Timeout counter (16 bits):**
  - Increments each ARB cycle while `o_locked`=1 and `i_req_valid[o_owner]`=0.
  - Clears on any grant and whenever unlocked.
  - At count == `IDLE_TIMEOUT`-1: `o_locked` <= 0, counter <= 0, `o_timeout` <= 1 for one cycle.
- **Simultaneous events:**
  - If the owner's byte arrives in the same cycle the count reaches its limit, the grant wins: no timeout, and the lock follows `i_req_last`.
  - Requesters other than the owner never get `o_req_ready` while locked, even if the owner is idle.
- `o_req_ready` is all zeros outside ARB, while `i_tx_ready`=0, and while `reset`=1.

## Timing
- **Reset values:**
  - State ARB.
  - `o_tx_valid`=0, `o_tx_data`=0x00.
  - `o_owner`=0, `next`=0.
  - `o_locked`=0, `o_timeout`=0, `o_busy`=0.
  - Timeout counter = 0.
- **Latency:** `o_req_ready` rises in the same cycle as valid when the arbiter is idle (ARB, tx ready, eligible). `o_tx_valid` follows in the next cycle.
- **Per-byte overhead:** one ARB cycle and one ISSUE cycle beyond the `uart_tx` frame. The `uart_tx` frame is 10 × 434 cycles at 50 MHz / 115200.
- **Reset mid-frame:** returns to the reset values on the next edge; no byte is accepted while reset is high. `uart_tx` shares the same reset, so no partial-frame handshake survives reset.
- `o_tx_data` must not change in ISSUE, WAIT_BUSY or WAIT_DONE.

## Test plan
- **Single byte:** req0 sends 0x55 with last=1, all idle → `o_req_ready`=0001 in the same cycle; `o_tx_valid` pulses once the next cycle; `o_tx_data`=0x55 held until the next grant. With `uart_tx` looped back into `uart_rx`, the receiver gets 0x55 and `o_locked` stays 0.
- **Round robin:** all four requesters hold valid with last=1 and data 0x10+k → grant order 0,1,2,3,0; exactly one `o_tx_valid` per frame.
- **Packet lock:** req1 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) while req0 and req2 are also valid → the three req1 bytes go out consecutively, then req2, then req0; `o_locked`=1 between the 0xA1 and 0xA3 grants.
- **Timeout:** `IDLE_TIMEOUT`=16; req2 sends one byte with last=0, then drops valid; req3 is valid → after 16 ARB cycles `o_timeout` pulses, and `o_req_ready[3]` is asserted in that same cycle.
- **Backpressure:** `i_tx_ready` is forced to 0 with all requesters valid → `o_req_ready`=0000 and `o_tx_valid`=0 indefinitely.
- **Reset in WAIT_DONE** → next cycle `o_busy`=0, `o_tx_data`=0x00, `o_locked`=0, `o_owner`=0; the first grant after reset goes to req0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N_REQ byte-stream requesters.
// Round-robin grant with a per-packet lock, an idle timeout that revokes a
// stale lock, and a transmit byte held stable for the whole uart_tx frame.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int IDLE_TIMEOUT = 65535,
  localparam int OWN_W       = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [N_REQ*8-1:0]   i_req_data,
  input  logic [N_REQ-1:0]     i_req_last,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_tx_valid,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_ready,
  output logic [OWN_W-1:0]     o_owner,
  output logic                 o_locked,
  output logic                 o_busy,
  output logic                 o_timeout
);

  // Count value at which an idle lock is revoked.
  localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_tx_data;
  logic [OWN_W-1:0]  r_owner;
  logic [OWN_W-1:0]  r_next;
  logic              r_locked;
  logic              r_timeout;
  logic [15:0]       r_idle_cnt;

  logic              w_grant_vld;
  logic [OWN_W-1:0]  w_grant_idx;
  logic [7:0]        w_grant_data;
  logic              w_grant_last;
  logic [OWN_W-1:0]  w_cand;
  logic              w_owner_vld;
  logic              w_idle_tick;

  // Requester index base+off, wrapped modulo N_REQ (works for non power-of-two N_REQ).
  function automatic logic [OWN_W-1:0] f_wrap(input logic [OWN_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return OWN_W'(s);
  endfunction

  assign w_owner_vld = i_req_valid[r_owner];
  // The owner is idle while parked in ARB under lock: this is what the timeout measures.
  assign w_idle_tick = (r_state == ST_ARB) && r_locked && !w_owner_vld;

  // Grant search: only the owner while locked, else first valid requester from r_next onwards.
  always_comb begin
    w_grant_vld  = 1'b0;
    w_grant_idx  = '0;
    w_grant_data = '0;
    w_grant_last = 1'b0;
    w_cand       = '0;
    if ((r_state == ST_ARB) && i_tx_ready && !reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        w_cand = f_wrap(r_next, i);
        if (!w_grant_vld && i_req_valid[w_cand] && (!r_locked || (w_cand == r_owner))) begin
          w_grant_vld  = 1'b1;
          w_grant_idx  = w_cand;
          w_grant_data = i_req_data[{w_cand, 3'b000} +: 8];
          w_grant_last = i_req_last[w_cand];
        end
      end
    end
  end

  // One-hot ready toward the requesters, only for the granted index.
  always_comb begin
    o_req_ready = '0;
    if (w_grant_vld) o_req_ready[w_grant_idx] = 1'b1;
  end

  // Next-state logic: one ISSUE pulse, then follow uart_tx ready low and back high.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_ARB:       if (w_grant_vld) w_state_nxt = ST_ISSUE;
      ST_ISSUE:     w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!i_tx_ready) w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (i_tx_ready) w_state_nxt = ST_ARB;
      default:      w_state_nxt = ST_ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ARB;
    else       r_state <= w_state_nxt;
  end

  // Owner, round-robin pointer, packet lock and idle timeout; a grant always beats a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= '0;
      r_next     <= '0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_timeout <= 1'b0;
      if (w_grant_vld) begin
        r_owner    <= w_grant_idx;
        r_next     <= f_wrap(w_grant_idx, 1);
        r_locked   <= !w_grant_last;
        r_idle_cnt <= '0;
      end else if (!r_locked) begin
        r_idle_cnt <= '0;
      end else if (w_idle_tick) begin
        if (r_idle_cnt == IDLE_LIMIT) begin
          r_locked   <= 1'b0;
          r_idle_cnt <= '0;
          r_timeout  <= 1'b1;
        end else begin
          r_idle_cnt <= r_idle_cnt + 16'd1;
        end
      end
    end
  end

  // Transmit byte: captured only on grant, so it stays put while uart_tx shifts it out.
  always_ff @(posedge clk) begin
    if (reset)            r_tx_data <= 8'h00;
    else if (w_grant_vld) r_tx_data <= w_grant_data;
  end

  assign o_tx_valid = (r_state == ST_ISSUE);
  assign o_tx_data  = r_tx_data;
  assign o_owner    = r_owner;
  assign o_locked   = r_locked;
  assign o_busy     = (r_state != ST_ARB);
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed table, hand-written corner sequences
// and randomized traffic checked against a behavioural model and a uart_tx stand-in.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   i_req_valid, i_req_last, o_req_ready;
  logic [31:0]  i_req_data;
  logic         o_tx_valid, i_tx_ready;
  logic [7:0]   o_tx_data;
  logic [1:0]   o_owner;
  logic         o_locked, o_busy, o_timeout;

  uart_tx_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
    .i_tx_ready(i_tx_ready), .o_owner(o_owner), .o_locked(o_locked),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus state
  logic [3:0]  s_valid, s_last;
  logic [31:0] s_data;
  bit          s_rst, force_low;

  // uart_tx stand-in: ready stays high u_hi cycles after a frame start, then low u_len cycles
  bit u_active;
  int u_hi, u_len;

  // Behavioural model: phase 0=ARB 1=ISSUE 2=WAIT_BUSY 3=WAIT_DONE
  int         m_st, m_owner, m_next, m_idle;
  logic [7:0] m_data;
  bit         m_locked, m_to;
  int         mg;

  // Observed DUT values for the hand sequences
  logic [3:0] dut_rdy;
  logic       dut_to, dut_lock, dut_busy;
  logic [1:0] dut_own;
  int         q_own[$];
  logic [7:0] q_dat[$];
  logic       q_lck[$];

  function automatic int model_grant();
    if (s_rst || m_st != 0 || !i_tx_ready) return -1;
    if (m_locked) return s_valid[m_owner] ? m_owner : -1;
    for (int off = 0; off < N; off++) begin
      int k = (m_next + off) % N;
      if (s_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (s_rst) begin
      m_st = 0; m_owner = 0; m_next = 0; m_idle = 0;
      m_data = 8'h00; m_locked = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_st == 0) begin
        if (g >= 0) begin
          m_data = s_data[8*g +: 8];
          m_owner = g;
          m_next = (g + 1) % N;
          m_locked = !s_last[g];
          m_idle = 0;
          m_st = 1;
        end else if (m_locked && !s_valid[m_owner]) begin
          m_idle++;
          if (m_idle == TO) begin
            m_locked = 0; m_idle = 0; m_to = 1;
          end
        end
      end else if (m_st == 1) m_st = 2;
      else if (m_st == 2) begin if (!i_tx_ready) m_st = 3; end
      else begin if (i_tx_ready) m_st = 0; end
    end
  endtask

  task automatic uart_update(input bit issued);
    if (s_rst) u_active = 0;
    else begin
      if (u_active) begin
        if (u_hi > 0) u_hi--;
        else begin
          u_len--;
          if (u_len == 0) u_active = 0;
        end
      end
      if (issued) begin
        u_active = 1;
        u_hi = $urandom_range(0, 2);
        u_len = $urandom_range(1, 4);
      end
    end
  endtask

  // One clock: drive at negedge, check 1 time unit later, advance model after posedge
  task automatic cycle();
    int g;
    logic [3:0] erdy;
    bit issued;
    @(negedge clk);
    reset = s_rst;
    i_req_valid = s_valid;
    i_req_data = s_data;
    i_req_last = s_last;
    i_tx_ready = !force_low && !(u_active && u_hi == 0);
    #1;
    g = model_grant();
    mg = g;
    erdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("req_ready", o_req_ready, erdy);
    if (!s_rst) begin
      chk("tx_valid", o_tx_valid, (m_st == 1));
      chk("tx_data", o_tx_data, m_data);
      chk("owner", o_owner, m_owner);
      chk("locked", o_locked, m_locked);
      chk("busy", o_busy, (m_st != 0));
      chk("timeout", o_timeout, m_to);
    end
    dut_rdy = o_req_ready; dut_to = o_timeout; dut_lock = o_locked;
    dut_busy = o_busy; dut_own = o_owner;
    if (o_tx_valid === 1'b1) begin
      q_own.push_back(int'(o_owner)); q_dat.push_back(o_tx_data); q_lck.push_back(o_locked);
    end
    issued = (m_st == 1) && !s_rst;
    @(posedge clk);
    model_update(g);
    uart_update(issued);
  endtask

  task automatic do_reset();
    s_rst = 1; s_valid = 4'hF; force_low = 0;
    cycle();
    s_rst = 0; s_valid = 4'h0; s_last = 4'h0; s_data = 32'h0;
    q_own.delete(); q_dat.delete(); q_lck.delete();
  endtask

  typedef struct {
    logic [3:0] v; logic [31:0] d; logic [3:0] l; logic txr;
    logic [3:0] rdy; logic txv; logic [7:0] dat; logic [1:0] own; logic lck; logic bsy;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int idle, c;
    bit done, arm;
    bit have[4];
    int gap[4];
    int exp_own[6];
    logic [7:0] exp_dat[6];
    logic exp_lck[6];
    int a_step;

    s_rst = 0; force_low = 0; s_valid = 0; s_last = 0; s_data = 0; u_active = 0;
    u_hi = 0; u_len = 0; m_st = 0; m_owner = 0; m_next = 0; m_idle = 0;
    m_data = 0; m_locked = 0; m_to = 0; mg = -1;

    //            v      d             l      txr  rdy    txv dat    own lck bsy
    tbl[0] = '{4'h1, 32'h0000_0055, 4'h1, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{4'h0, 32'h0000_0000, 4'h0, 1'b1, 4'h0, 1'b1, 8'h55, 2'd0, 1'b0, 1'b1};
    tbl[2] = '{4'h0, 32'h0000_0000, 4'h0, 1'b0, 4'h0, 1'b0, 8'h55, 2'd0, 1'b0, 1'b1};
    tbl[3] = '{4'hF, 32'h1312_1110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h55, 2'd0, 1'b0, 1'b1};
    tbl[4] = '{4'hF, 32'h1312_1110, 4'hF, 1'b1, 4'h0, 1'b0, 8'h55, 2'd0, 1'b0, 1'b1};
    tbl[5] = '{4'hF, 32'h1312_1110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h55, 2'd0, 1'b0, 1'b0};
    tbl[6] = '{4'hF, 32'h1312_1110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h55, 2'd0, 1'b0, 1'b0};
    tbl[7] = '{4'hF, 32'h1312_1110, 4'hF, 1'b1, 4'h2, 1'b0, 8'h55, 2'd0, 1'b0, 1'b0};
    tbl[8] = '{4'h0, 32'h0000_0000, 4'h0, 1'b1, 4'h0, 1'b1, 8'h11, 2'd1, 1'b0, 1'b1};
    tbl[9] = '{4'h0, 32'h0000_0000, 4'h0, 1'b1, 4'h0, 1'b0, 8'h11, 2'd1, 1'b0, 1'b1};

    // Reset with all requesters valid: nothing accepted, reset values visible
    @(negedge clk);
    reset = 1; i_req_valid = 4'hF; i_req_data = 32'h1312_1110; i_req_last = 4'hF; i_tx_ready = 1;
    @(negedge clk); #1;
    chk("rst_req_ready", o_req_ready, 4'h0);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_tx_data", o_tx_data, 8'h00);
    chk("rst_owner", o_owner, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout, 0);

    // Single byte, backpressure in ARB, then round-robin pointer moved to req1
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = 0; i_req_valid = tbl[i].v; i_req_data = tbl[i].d;
      i_req_last = tbl[i].l; i_tx_ready = tbl[i].txr;
      #1;
      chk($sformatf("tbl%0d_req_ready", i), o_req_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_tx_valid", i), o_tx_valid, tbl[i].txv);
      chk($sformatf("tbl%0d_tx_data", i), o_tx_data, tbl[i].dat);
      chk($sformatf("tbl%0d_owner", i), o_owner, tbl[i].own);
      chk($sformatf("tbl%0d_locked", i), o_locked, tbl[i].lck);
      chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_timeout", i), o_timeout, 0);
    end

    // Round robin: all valid, last=1, data 0x10+k -> 0,1,2,3,0
    do_reset();
    s_valid = 4'hF; s_data = 32'h1312_1110; s_last = 4'hF;
    for (c = 0; c < 300 && q_own.size() < 5; c++) cycle();
    s_valid = 4'h0;
    for (int i = 0; i < 10; i++) cycle();
    chk("rr_count", q_own.size(), 5);
    for (int i = 0; i < 5 && i < q_own.size(); i++) begin
      chk($sformatf("rr_owner%0d", i), q_own[i], i % 4);
      chk($sformatf("rr_data%0d", i), q_dat[i], 8'h10 + 8'(i % 4));
    end

    // Packet lock: req1 sends A1,A2,A3 while req0/req2 also wait
    do_reset();
    s_valid = 4'h7; s_data = 32'h00B2_A100; s_last = 4'h5;
    a_step = 0;
    exp_own = '{0, 1, 1, 1, 2, 0};
    exp_dat = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hB2, 8'h0F};
    exp_lck = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (c = 0; c < 400 && q_own.size() < 6; c++) begin
      cycle();
      if (mg == 0) begin
        if (s_data[7:0] == 8'h00) s_data[7:0] = 8'h0F; else s_valid[0] = 0;
      end else if (mg == 1) begin
        a_step++;
        if (a_step == 1) s_data[15:8] = 8'hA2;
        else if (a_step == 2) begin s_data[15:8] = 8'hA3; s_last[1] = 1; end
        else s_valid[1] = 0;
      end else if (mg == 2) s_valid[2] = 0;
    end
    chk("lock_count", q_own.size(), 6);
    for (int i = 0; i < 6 && i < q_own.size(); i++) begin
      chk($sformatf("lock_owner%0d", i), q_own[i], exp_own[i]);
      chk($sformatf("lock_data%0d", i), q_dat[i], exp_dat[i]);
      chk($sformatf("lock_locked%0d", i), q_lck[i], exp_lck[i]);
    end

    // Timeout: req2 locks then goes idle, req3 waits
    do_reset();
    s_valid = 4'h4; s_data = 32'h3322_0000; s_last = 4'h8;
    for (c = 0; c < 50 && mg != 2; c++) cycle();
    s_valid = 4'h8;
    idle = 0; done = 0;
    for (c = 0; c < 300 && !done; c++) begin
      cycle();
      if (dut_to === 1'b1) begin
        chk("to_ready_same_cycle", dut_rdy, 4'h8);
        chk("to_idle_arb_cycles", idle, TO);
        done = 1;
      end else if (dut_lock && !dut_busy && dut_own == 2'd2) idle++;
    end
    chk("to_seen", done, 1);

    // Owner byte arrives in the very cycle the count hits its limit: grant wins
    do_reset();
    s_valid = 4'h4; s_data = 32'h3322_0000; s_last = 4'h8;
    for (c = 0; c < 50 && mg != 2; c++) cycle();
    s_valid = 4'h8;
    idle = 0; done = 0; arm = 0;
    for (c = 0; c < 300 && !done; c++) begin
      if (m_st == 0 && m_locked && idle == TO - 1) begin
        s_valid[2] = 1; s_data[23:16] = 8'h2F; s_last[2] = 1; arm = 1;
      end
      cycle();
      if (arm) begin
        chk("edge_grant_owner", dut_rdy, 4'h4);
        chk("edge_no_timeout", dut_to, 0);
        done = 1;
      end else if (dut_lock && !dut_busy) idle++;
    end
    chk("edge_reached", done, 1);
    s_valid = 4'h8;
    cycle();
    chk("edge_after_timeout", dut_to, 0);
    chk("edge_after_locked", dut_lock, 0);
    chk("edge_after_data", o_tx_data, 8'h2F);

    // Backpressure: uart never ready, nothing granted
    do_reset();
    s_valid = 4'hF; s_data = 32'h1312_1110; s_last = 4'hF; force_low = 1;
    for (int i = 0; i < 30; i++) cycle();
    chk("bp_no_tx", q_own.size(), 0);
    force_low = 0;

    // Reset while in WAIT_DONE
    do_reset();
    s_valid = 4'h1; s_data = 32'h0000_005A; s_last = 4'h0;
    for (c = 0; c < 50 && m_st != 3; c++) begin
      cycle();
      if (mg == 0) s_valid = 4'h0;
    end
    chk("wd_reached", m_st, 3);
    s_rst = 1; s_valid = 4'hF; s_data = 32'h1312_1110; s_last = 4'hF;
    cycle();
    s_rst = 0;
    cycle();
    chk("wd_busy", dut_busy, 0);
    chk("wd_tx_data", o_tx_data, 8'h00);
    chk("wd_locked", dut_lock, 0);
    chk("wd_owner", dut_own, 0);
    chk("wd_first_grant", dut_rdy, 4'h1);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 4; k++) begin have[k] = 0; gap[k] = 0; end
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!have[k]) begin
          if (gap[k] > 0) gap[k]--;
          else if ($urandom_range(0, 1) == 1) begin
            have[k] = 1;
            s_data[8*k +: 8] = 8'($urandom_range(0, 255));
            s_last[k] = ($urandom_range(0, 2) != 0);
          end
        end
        s_valid[k] = have[k];
      end
      force_low = ($urandom_range(0, 19) == 0);
      s_rst = ($urandom_range(0, 599) == 0);
      cycle();
      if (s_rst) begin
        for (int k = 0; k < 4; k++) have[k] = 0;
      end else if (mg >= 0) begin
        have[mg] = 0;
        gap[mg] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(0, 2);
      end
    end
    s_rst = 0; force_low = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
